// File: rtl/bus_arbiter_pkg.sv
// Shared constants, types and the round-robin pick for the bus arbiter.
// Requester count, data width and FSM encoding live here only.
package bus_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 8;
  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int CNT_W   = 4;

  typedef logic [NUM_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0]   idx_t;
  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [CNT_W-1:0]   cnt_t;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // First set bit at or above p, wrapping past the top index.
  function automatic idx_t rr_pick(
    input req_t r,
    input idx_t p
  );
    idx_t idx;
    idx_t win;
    logic hit;
    win = '0;
    hit = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = p + idx_t'(k);
      if (!hit && r[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

// File: rtl/byte_buff.sv
// Expands a single select bit into a full data-width mask.
// Used once per requester to gate its byte onto the bus.
module byte_buff
  import bus_arbiter_pkg::*;
(
  input  logic              sel,
  output logic [DATA_W-1:0] mask
);

  assign mask = {DATA_W{sel}};

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with hold-limit preemption.
// Grant, owner and valid are registered; the data mux follows gnt.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic [DATA_W-1:0]  d0,
  input  logic [DATA_W-1:0]  d1,
  input  logic [DATA_W-1:0]  d2,
  input  logic [DATA_W-1:0]  d3,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   owner,
  output logic               bus_valid,
  output logic [DATA_W-1:0]  bus_out
);

  localparam cnt_t CNT_MAX = cnt_t'(HOLD_MAX - 1);

  state_t state;
  state_t state_n;
  req_t   gnt_n;
  idx_t   owner_n;
  logic   valid_n;
  idx_t   ptr;
  idx_t   ptr_n;
  cnt_t   cnt;
  cnt_t   cnt_n;

  req_t   others;
  idx_t   win;
  logic   take;
  logic   rel;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= '0;
      owner     <= '0;
      bus_valid <= 1'b0;
      ptr       <= '0;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      gnt       <= gnt_n;
      owner     <= owner_n;
      bus_valid <= valid_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    owner_n = owner;
    valid_n = bus_valid;
    ptr_n   = ptr;
    cnt_n   = cnt;
    win     = '0;
    take    = 1'b0;
    others  = req & ~gnt;
    rel     = !req[owner] ||
              ((cnt == CNT_MAX) && |others);

    unique case (state)
      IDLE: begin
        take = |others;
      end
      GRANT: begin
        if (!rel) begin
          if (cnt != CNT_MAX) cnt_n = cnt + cnt_t'(1);
        end else if (|others) begin
          take = 1'b1;
        end else begin
          state_n = IDLE;
          gnt_n   = '0;
          owner_n = '0;
          valid_n = 1'b0;
        end
      end
    endcase

    // Owner is masked out of the pool, so a preempting holder never re-wins.
    if (take) begin
      win     = rr_pick(others, ptr);
      state_n = GRANT;
      gnt_n   = req_t'(1) << win;
      owner_n = win;
      valid_n = 1'b1;
      ptr_n   = win + idx_t'(1);
      cnt_n   = '0;
    end
  end

  data_t dv   [NUM_REQ];
  data_t mask [NUM_REQ];

  assign dv[0] = d0;
  assign dv[1] = d1;
  assign dv[2] = d2;
  assign dv[3] = d3;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_buf
    byte_buff u_buf (
      .sel  (gnt[g]),
      .mask (mask[g])
    );
  end

  always_comb begin
    bus_out = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      bus_out = bus_out | (dv[i] & mask[i]);
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter with HOLD_MAX = 4.
// Expected grants are queued per edge and popped after the edge.
module tb_bus_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [7:0] d0, d1, d2, d3;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       bus_valid;
  logic [7:0] bus_out;

  int tests = 0;
  int fails = 0;
  logic running = 1'b0;

  typedef struct packed {
    logic [3:0] gnt;
    logic [1:0] owner;
    logic       valid;
    logic [7:0] bus;
  } exp_t;

  exp_t q[$];
  logic [7:0] dv [4];

  bus_arbiter #(.HOLD_MAX(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .d0        (d0),
    .d1        (d1),
    .d2        (d2),
    .d3        (d3),
    .gnt       (gnt),
    .owner     (owner),
    .bus_valid (bus_valid),
    .bus_out   (bus_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [3:0] g);
    exp_t e;
    e.gnt   = g;
    e.owner = 2'd0;
    e.valid = |g;
    e.bus   = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) begin
        e.owner = 2'(i);
        e.bus   = dv[i];
      end
    end
    return e;
  endfunction

  function automatic logic [7:0] sel_ref(input logic [3:0] g);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < 4; i++) begin
      if (g[i]) b = b | dv[i];
    end
    return b;
  endfunction

  task automatic expect_edge(input string tag, input logic [3:0] eg);
    exp_t e;
    q.push_back(mk(eg));
    @(posedge clk);
    #1;
    e = q.pop_front();
    check({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
    check({tag, ".owner"}, 32'(owner), 32'(e.owner));
    check({tag, ".valid"}, 32'(bus_valid), 32'(e.valid));
    check({tag, ".bus"}, 32'(bus_out), 32'(e.bus));
  endtask

  task automatic step(
    input string      tag,
    input logic [3:0] r,
    input logic [3:0] eg
  );
    @(negedge clk);
    req = r;
    expect_edge(tag, eg);
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".gnt"}, 32'(gnt), 32'h0);
    check({tag, ".owner"}, 32'(owner), 32'h0);
    check({tag, ".valid"}, 32'(bus_valid), 32'h0);
    check({tag, ".bus"}, 32'(bus_out), 32'h0);
  endtask

  always @(negedge clk) begin
    if (running && rst_n) begin
      check("onehot0", 32'($onehot0(gnt)), 32'h1);
      check("bus_sel", 32'(bus_out), 32'(sel_ref(gnt)));
    end
  end

  initial begin
    rst_n = 1'b0;
    req   = 4'b0000;
    d0 = 8'hA5;
    d1 = 8'h3C;
    d2 = 8'h5A;
    d3 = 8'hC3;
    dv[0] = d0;
    dv[1] = d1;
    dv[2] = d2;
    dv[3] = d3;

    #3;
    check_zero("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    running = 1'b1;

    // single requester 0
    for (int i = 0; i < 4; i++) step("r0", 4'b0001, 4'b0001);
    step("r0_drop", 4'b0000, 4'b0000);

    // fresh reset so rotation starts at ptr=0
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("rst2");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) step("rot0", 4'b1111, 4'b0001);
    for (int i = 0; i < 4; i++) step("rot1", 4'b1111, 4'b0010);
    for (int i = 0; i < 4; i++) step("rot2", 4'b1111, 4'b0100);
    for (int i = 0; i < 4; i++) step("rot3", 4'b1111, 4'b1000);
    for (int i = 0; i < 4; i++) step("rot4", 4'b1111, 4'b0001);
    step("rot_end", 4'b0000, 4'b0000);

    // lone requester 3: no preemption, saturated hold
    for (int i = 0; i < 10; i++) step("r3", 4'b1000, 4'b1000);
    step("r3_drop", 4'b0000, 4'b0000);

    // saturated holder preempted as soon as another asks
    for (int i = 0; i < 5; i++) step("sat3", 4'b1000, 4'b1000);
    step("sat_pre", 4'b1001, 4'b0001);
    step("sat_end", 4'b0000, 4'b0000);

    // owner 2 drops as requester 1 rises: direct handoff
    step("h2a", 4'b0100, 4'b0100);
    step("h2b", 4'b0100, 4'b0100);
    step("h2to1", 4'b0010, 4'b0010);
    for (int i = 0; i < 3; i++) step("h1", 4'b0011, 4'b0010);
    step("h1pre", 4'b0011, 4'b0001);
    step("h_end", 4'b0000, 4'b0000);

    // reset mid-grant
    step("g3a", 4'b1000, 4'b1000);
    step("g3b", 4'b1000, 4'b1000);
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0110;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    rst_n = 1'b1;
    expect_edge("post_rst", 4'b0010);
    for (int i = 0; i < 3; i++) step("pr1", 4'b0110, 4'b0010);
    step("pr_pre", 4'b0110, 4'b0100);
    step("pr_end", 4'b0000, 4'b0000);

    @(negedge clk);
    running = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
